dbg_spi_sched: RTL

Debug-probe scheduler for the SoC's SPI trace port. It samples up to NCH 32-bit probe words (pc, imem data, dmem wdata, dmem rdata) at each CPU step boundary and serialises the enabled ones over one shared sck/mosi pair, with a per-channel active-low chip select. When all enabled words have been sent, it issues a one-cycle CPU clock-enable, so the CPU advances exactly one instruction per completed trace burst. It replaces free-running per-channel shifters and derived CPU clocks with a single sequenced, single-clock controller.

---
 rtl/dbg_pkg.sv | 15 +
 rtl/spi_frame_tx.sv | 60 ++++++
 rtl/dbg_spi_sched.sv | 99 +++++++++
 3 files changed

// File: rtl/dbg_pkg.sv
// dbg_pkg: shared state type and helpers for the SPI debug-probe scheduler
package dbg_pkg;
   typedef enum logic [2:0] {IDLE, SNAP, SHIFT, GAP, STEP} state_e;
   localparam int PROBE_W = 32;
   function automatic int frame_halves(input int w);
      return 2 * w + 1;
   endfunction
   localparam int FRAME_HALVES = frame_halves(PROBE_W);
   function automatic logic [2:0] lowest_set(input logic [7:0] m);
      logic [2:0] r;
      r = '0;
      for (int i = 7; i >= 0; i--) if (m[i]) r = 3'(i);
      return r;
   endfunction
endpackage

// File: rtl/spi_frame_tx.sv
// spi_frame_tx: one SPI mode-0 frame, MSB first, ending with a low-sck hold half-period
module spi_frame_tx
   import dbg_pkg::*;
#(
   parameter int W   = PROBE_W,
   parameter int DIV = 100
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_i,
   input  logic [W-1:0] word_i,
   output logic         done_o,
   output logic         sck_o,
   output logic         mosi_o
);
   localparam int HALVES = frame_halves(W);
   localparam int HW = $clog2(HALVES + 1);
   localparam int CW = $clog2(DIV + 1);
   logic          act_q;
   logic [CW-1:0] cnt_q;
   logic [HW-1:0] half_q;
   logic [W-1:0]  sr_q;
   logic          sck_q, mosi_q, tick;
   assign tick   = act_q && cnt_q == '0;
   assign done_o = tick && half_q == HW'(HALVES - 1);
   assign sck_o  = sck_q;
   assign mosi_o = mosi_q;
   // leaving an odd half drops sck and presents the next bit; leaving an even half raises sck
   always_ff @(posedge clk) begin
      if (rst) begin
         act_q  <= 1'b0;
         cnt_q  <= '0;
         half_q <= '0;
         sr_q   <= '0;
         sck_q  <= 1'b0;
         mosi_q <= 1'b0;
      end else if (start_i) begin
         act_q  <= 1'b1;
         cnt_q  <= CW'(DIV - 1);
         half_q <= '0;
         sr_q   <= word_i;
         sck_q  <= 1'b0;
         mosi_q <= word_i[W-1];
      end else if (done_o) begin
         act_q  <= 1'b0;
         sck_q  <= 1'b0;
         mosi_q <= 1'b0;
      end else if (act_q) begin
         cnt_q <= tick ? CW'(DIV - 1) : cnt_q - 1'b1;
         if (tick) begin
            half_q <= half_q + 1'b1;
            sck_q  <= ~half_q[0];
            if (half_q[0]) begin
               sr_q   <= sr_q << 1;
               mosi_q <= sr_q[W-2];
            end
         end
      end
   end
endmodule

// File: rtl/dbg_spi_sched.sv
// dbg_spi_sched: snapshots probe words, sends enabled ones over shared SPI, then steps the CPU once
module dbg_spi_sched
   import dbg_pkg::*;
#(
   parameter int NCH = 4,
   parameter int W   = PROBE_W,
   parameter int DIV = 100
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH*W-1:0] ch_data,
   input  logic [NCH-1:0]   ch_en,
   input  logic             run,
   input  logic             step,
   output logic             cpu_ce,
   output logic             busy,
   output logic             spi_sck,
   output logic             spi_mosi,
   output logic [NCH-1:0]   spi_cs_n
);
   localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
   localparam int CW = $clog2(DIV + 1);
   state_e                 state_q, state_d;
   logic [NCH-1:0][W-1:0]  data_q, ch_w;
   logic [NCH-1:0]         mask_q, mask_d, rest, cs_n_q;
   logic [IW-1:0]          idx_q, idx_d;
   logic [CW-1:0]          gcnt_q, gcnt_d;
   logic                   pend_q, pend_d, cpu_ce_q, busy_q, start, done;
   assign ch_w     = ch_data;
   assign rest     = mask_q & ~(NCH'(1) << idx_q);
   assign start    = state_d == SHIFT && state_q != SHIFT;
   assign cpu_ce   = cpu_ce_q;
   assign busy     = busy_q;
   assign spi_cs_n = cs_n_q;
   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      idx_d   = idx_q;
      gcnt_d  = gcnt_q;
      pend_d  = pend_q | (step & (state_q != IDLE));
      case (state_q)
         IDLE: if (run || step || pend_q) begin
            state_d = SNAP;
            pend_d  = 1'b0;
         end
         SNAP: begin
            mask_d  = ch_en;
            idx_d   = IW'(lowest_set(8'(ch_en)));
            state_d = ch_en == '0 ? STEP : SHIFT;
         end
         SHIFT: if (done) begin
            state_d = GAP;
            gcnt_d  = CW'(DIV - 1);
         end
         GAP: begin
            gcnt_d = gcnt_q - 1'b1;
            if (gcnt_q == '0) begin
               mask_d  = rest;
               idx_d   = IW'(lowest_set(8'(rest)));
               state_d = rest == '0 ? STEP : SHIFT;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         data_q   <= '0;
         mask_q   <= '0;
         idx_q    <= '0;
         gcnt_q   <= '0;
         pend_q   <= 1'b0;
         cpu_ce_q <= 1'b0;
         busy_q   <= 1'b0;
         cs_n_q   <= '1;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         idx_q    <= idx_d;
         gcnt_q   <= gcnt_d;
         pend_q   <= pend_d;
         if (state_q == SNAP) data_q <= ch_w;
         cpu_ce_q <= state_d == STEP;
         busy_q   <= state_d != IDLE;
         cs_n_q   <= state_d == SHIFT ? ~(NCH'(1) << idx_d) : '1;
      end
   end
   // the first frame starts in the SNAP cycle, before data_q holds the snapshot
   spi_frame_tx #(.W(W), .DIV(DIV)) u_tx (
      .clk     (clk),
      .rst     (rst),
      .start_i (start),
      .word_i  (state_q == SNAP ? ch_w[idx_d] : data_q[idx_d]),
      .done_o  (done),
      .sck_o   (spi_sck),
      .mosi_o  (spi_mosi)
   );
endmodule
